// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction game: FSM state encoding,
// the score ceiling and the LFSR polynomial used by the delay generator.
package reaction_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DELAY,
    ST_TIMING,
    ST_CAPTURE
  } state_t;

  localparam int          TIME_MAX  = 9999;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // One step of the right-shifting Galois LFSR; a non-zero seed never reaches zero.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond strobe: counts 0..CLK_PER_MS-1 and flags the terminal count.
// A synchronous clear restarts the period so the next tick lands CLK_PER_MS cycles later.
module ms_tick_gen #(
  parameter int CLK_PER_MS = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int            CW   = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_PER_MS - 1);

  logic [CW-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its inputs, independent of block order.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/reaction_delay_timer.sv
// Reaction-game responder: random delay, ready pulse, reaction measurement and
// best-score register. Define HISCORE_EN to build the best-score tracker.
module reaction_delay_timer
  import reaction_pkg::*;
#(
  parameter int CLK_PER_MS   = 50000,
  parameter int MIN_DELAY_MS = 1000,
  parameter int SPAN_BITS    = 12,
  parameter int TIME_W       = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              stop,
  output logic              ready,
  output logic              early,
  output logic [TIME_W-1:0] react_ms,
  output logic              valid,
  output logic              timeout,
  output logic [TIME_W-1:0] hi_score,
  output logic              new_hi
);

  localparam logic [TIME_W-1:0] T_MAX      = TIME_W'(TIME_MAX);
  localparam logic [TIME_W-1:0] T_MAX_M1   = TIME_W'(TIME_MAX - 1);
  localparam logic [TIME_W-1:0] DELAY_BASE = TIME_W'(MIN_DELAY_MS);

  state_t            state, next_state;
  logic [15:0]       lfsr;
  logic [TIME_W-1:0] remain;
  logic [TIME_W-1:0] count;
  logic [TIME_W-1:0] delay_sum;
  logic              tick;

  logic              tick_clr;
  logic              load_remain;
  logic              dec_remain;
  logic              start_timing;
  logic              inc_count;
  logic              early_set;
  logic              capture;
  logic              capture_to;
  logic [TIME_W-1:0] capture_val;

  assign delay_sum = DELAY_BASE + TIME_W'(lfsr[SPAN_BITS-1:0]);

  ms_tick_gen #(
    .CLK_PER_MS(CLK_PER_MS)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .clr (tick_clr),
    .tick(tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    next_state   = state;
    tick_clr     = 1'b0;
    load_remain  = 1'b0;
    dec_remain   = 1'b0;
    start_timing = 1'b0;
    inc_count    = 1'b0;
    early_set    = 1'b0;
    capture      = 1'b0;
    capture_to   = 1'b0;
    capture_val  = count;
    unique case (state)
      ST_IDLE: begin
        if (en) begin
          load_remain = 1'b1;
          tick_clr    = 1'b1;
          next_state  = ST_DELAY;
        end
      end
      // Abort outranks an early press, which outranks the final delay tick.
      ST_DELAY: begin
        if (!en) begin
          next_state = ST_IDLE;
        end else if (stop) begin
          early_set  = 1'b1;
          next_state = ST_IDLE;
        end else if (tick) begin
          if (remain <= TIME_W'(1)) begin
            start_timing = 1'b1;
            tick_clr     = 1'b1;
            next_state   = ST_TIMING;
          end else begin
            dec_remain = 1'b1;
          end
        end
      end
      // A press on a tick captures the pre-increment count, including the saturating tick.
      ST_TIMING: begin
        if (stop) begin
          capture     = 1'b1;
          capture_val = count;
          next_state  = ST_CAPTURE;
        end else if (tick) begin
          if (count >= T_MAX_M1) begin
            capture     = 1'b1;
            capture_to  = 1'b1;
            capture_val = T_MAX;
            next_state  = ST_CAPTURE;
          end else begin
            inc_count = 1'b1;
          end
        end
      end
      ST_CAPTURE: next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr     <= LFSR_SEED;
      remain   <= '0;
      count    <= '0;
      ready    <= 1'b0;
      early    <= 1'b0;
      valid    <= 1'b0;
      timeout  <= 1'b0;
      react_ms <= '0;
    end else begin
      lfsr  <= lfsr_step(lfsr);
      ready <= start_timing;
      early <= early_set;
      valid <= capture;

      if (load_remain) begin
        remain <= delay_sum;
      end else if (dec_remain) begin
        remain <= remain - TIME_W'(1);
      end

      if (start_timing) begin
        count <= '0;
      end else if (inc_count) begin
        count <= count + TIME_W'(1);
      end

      // The result is registered on the stop edge so it is already visible while valid is high.
      if (capture) begin
        react_ms <= capture_val;
        timeout  <= capture_to;
      end
    end
  end

`ifdef HISCORE_EN
  logic hi_better;

  assign hi_better = capture && !capture_to && (capture_val < hi_score);

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_score <= T_MAX;
      new_hi   <= 1'b0;
    end else begin
      new_hi <= hi_better;
      if (hi_better) begin
        hi_score <= capture_val;
      end
    end
  end
`else
  assign hi_score = T_MAX;
  assign new_hi   = 1'b0;
`endif

endmodule
